// File: rtl/wrdm_desc_arb.sv
// Round-robin arbiter that locks the write-data-mover descriptor port to one ring engine per burst.
// Define WRDM_ARB_STATS_EN to add per-port completed-burst counters on burst_cnt.
module wrdm_desc_arb #(
  parameter int         NUM_PORTS = 4,
  parameter int         DESC_W    = 174,
  parameter logic [7:0] DONE_ID   = 8'hFE,
  localparam int        GW        = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_PORTS-1:0]        req_valid,
  input  logic [NUM_PORTS*DESC_W-1:0] req_data,
  output logic [NUM_PORTS-1:0]        req_ready,
  output logic                        wrdm_desc_valid,
  output logic [DESC_W-1:0]           wrdm_desc_data,
  input  logic                        wrdm_desc_ready,
  output logic [GW-1:0]               grant_id,
  output logic                        busy
`ifdef WRDM_ARB_STATS_EN
  ,
  output logic [NUM_PORTS*32-1:0]     burst_cnt
`endif
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t              state_q, state_d;
  logic [GW-1:0]       grant_q, grant_d;
  logic [GW-1:0]       last_q, last_d;
  logic                out_vld_q, out_vld_d;
  logic [DESC_W-1:0]   out_data_q, out_data_d;

  logic [DESC_W-1:0]   sel_data;
  logic                slot_free;
  logic                accept;
  logic                done;
  logic [GW-1:0]       pick;
  logic                pick_vld;

  // Search upward from the port after the last winner, wrapping around.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      if (!pick_vld && req_valid[(int'(last_q) + k) % NUM_PORTS]) begin
        pick_vld = 1'b1;
        pick     = GW'((int'(last_q) + k) % NUM_PORTS);
      end
    end
  end

  assign sel_data  = req_data[int'(grant_q)*DESC_W +: DESC_W];
  assign slot_free = ~out_vld_q | wrdm_desc_ready;
  assign accept    = (state_q == LOCKED) & slot_free & req_valid[grant_q];
  assign done      = accept & (sel_data[159:152] == DONE_ID);

  always_comb begin
    req_ready = '0;
    if (state_q == LOCKED) begin
      req_ready[grant_q] = slot_free;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          grant_d = pick;
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (done) begin
          last_d  = grant_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output register: a fresh accept overwrites; otherwise a consume empties it.
  always_comb begin
    out_vld_d  = out_vld_q;
    out_data_d = out_data_q;
    if (accept) begin
      out_vld_d  = 1'b1;
      out_data_d = sel_data;
    end else if (wrdm_desc_ready) begin
      out_vld_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      last_q     <= GW'(NUM_PORTS - 1);
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      out_vld_q  <= out_vld_d;
      out_data_q <= out_data_d;
    end
  end

  assign wrdm_desc_valid = out_vld_q;
  assign wrdm_desc_data  = out_data_q;
  assign grant_id        = grant_q;
  assign busy            = (state_q == LOCKED);

`ifdef WRDM_ARB_STATS_EN
  logic [NUM_PORTS*32-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (done) begin
      cnt_q[int'(grant_q)*32 +: 32] <= cnt_q[int'(grant_q)*32 +: 32] + 32'd1;
    end
  end

  assign burst_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_wrdm_desc_arb.sv
// Directed bench for wrdm_desc_arb: burst-level arbitration model plus literal expectations.
module tb_wrdm_desc_arb;
  localparam int         N    = 4;
  localparam int         DW   = 174;
  localparam int         GW   = 2;
  localparam logic [7:0] DONE = 8'hFE;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      req_valid;
  logic [N*DW-1:0]   req_data;
  logic [N-1:0]      req_ready;
  logic              wv;
  logic [DW-1:0]     wd;
  logic              wr;
  logic [GW-1:0]     grant_id;
  logic              busy;
`ifdef WRDM_ARB_STATS_EN
  logic [N*32-1:0]   burst_cnt;
`endif

  always #5 clk = ~clk;

  wrdm_desc_arb #(.NUM_PORTS(N), .DESC_W(DW), .DONE_ID(DONE)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .wrdm_desc_valid(wv), .wrdm_desc_data(wd), .wrdm_desc_ready(wr),
    .grant_id(grant_id), .busy(busy)
`ifdef WRDM_ARB_STATS_EN
    , .burst_cnt(burst_cnt)
`endif
  );

  int checks = 0;
  int failures = 0;

  // Model state: lock owner, last winner, output slot, per-port burst counts.
  bit            m_locked;
  int            m_gnt;
  int            m_last;
  bit            m_ov;
  logic [DW-1:0] m_od;
  int            m_cnt [N];
  bit            prev_busy;
  int            cyc;

  logic [DW-1:0] pq [N][$];
  bit            rp [$];
  logic [15:0]   deliv [$];
  int            deliv_cyc [$];
  int            glog [$];

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk(input logic [7:0] p, input logic [7:0] s, input logic [7:0] id);
    logic [DW-1:0] d;
    d = '0;
    d[47:16]    = $urandom;
    d[79:48]    = $urandom;
    d[111:80]   = $urandom;
    d[143:112]  = $urandom;
    d[151:144]  = 8'($urandom);
    d[173:160]  = 14'($urandom);
    d[159:152]  = id;
    d[15:0]     = {p, s};
    return d;
  endfunction

  task automatic drive();
    wr = (rp.size() != 0) ? rp.pop_front() : 1'b1;
    for (int i = 0; i < N; i++) begin
      req_valid[i] = (pq[i].size() != 0);
      req_data[i*DW +: DW] = (pq[i].size() != 0) ? pq[i][0] : '0;
    end
  endtask

  task automatic step();
    logic [N-1:0]  exp_rdy;
    logic [DW-1:0] d;
    bit            was;
    bit            pop [N];
    @(negedge clk);
    cyc++;
    exp_rdy = '0;
    if (m_locked && (!m_ov || wr)) exp_rdy[m_gnt] = 1'b1;
    chk("busy", DW'(busy), DW'(m_locked));
    chk("grant_id", DW'(grant_id), DW'(m_gnt));
    chk("req_ready", DW'(req_ready), DW'(exp_rdy));
    chk("desc_valid", DW'(wv), DW'(m_ov));
    if (m_ov) chk("desc_data", wd, m_od);
`ifdef WRDM_ARB_STATS_EN
    for (int i = 0; i < N; i++) chk("burst_cnt", DW'(burst_cnt[i*32 +: 32]), DW'(m_cnt[i]));
`endif
    if (busy && !prev_busy) glog.push_back(int'(grant_id));
    prev_busy = busy;
    if (wv && wr) begin
      deliv.push_back(wd[15:0]);
      deliv_cyc.push_back(cyc);
    end
    was = m_locked;
    for (int i = 0; i < N; i++) pop[i] = 1'b0;
    if (m_locked && exp_rdy != '0 && req_valid[m_gnt]) begin
      d = req_data[m_gnt*DW +: DW];
      m_ov = 1'b1;
      m_od = d;
      pop[m_gnt] = 1'b1;
      if (d[159:152] == DONE) begin
        m_locked = 1'b0;
        m_last = m_gnt;
        m_cnt[m_gnt]++;
      end
    end else if (m_ov && wr) begin
      m_ov = 1'b0;
    end
    if (!was) begin
      for (int k = 1; k <= N; k++) begin
        if (!m_locked && req_valid[(m_last + k) % N]) begin
          m_locked = 1'b1;
          m_gnt = (m_last + k) % N;
        end
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (pop[i]) void'(pq[i].pop_front());
    drive();
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < N; i++) if (pq[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic run();
    int n;
    n = 0;
    drive();
    while (!(all_empty() && !m_ov && !m_locked) && n < 600) begin
      step();
      n++;
    end
    chk("run_timeout", DW'(n >= 600), DW'(0));
    step();
    step();
  endtask

  // Reset is asserted between clock edges; outputs must clear with no edge.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_valid", DW'(wv), DW'(0));
    chk("rst_data", wd, '0);
    chk("rst_ready", DW'(req_ready), DW'(0));
    chk("rst_grant", DW'(grant_id), DW'(0));
    chk("rst_busy", DW'(busy), DW'(0));
`ifdef WRDM_ARB_STATS_EN
    chk("rst_cnt", DW'(burst_cnt), DW'(0));
`endif
    m_locked = 1'b0; m_gnt = 0; m_last = N - 1; m_ov = 1'b0; m_od = '0;
    prev_busy = 1'b0;
    for (int i = 0; i < N; i++) begin
      m_cnt[i] = 0;
      pq[i].delete();
    end
    rp.delete(); deliv.delete(); deliv_cyc.delete(); glog.delete();
    drive();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic chk_glog(input string nm, input int e [$]);
    chk({nm, "_grants"}, DW'(glog.size()), DW'(e.size()));
    for (int i = 0; i < e.size(); i++) chk({nm, "_grant"}, DW'(glog[i]), DW'(e[i]));
  endtask

  task automatic chk_deliv(input string nm, input logic [15:0] e [$]);
    chk({nm, "_count"}, DW'(deliv.size()), DW'(e.size()));
    for (int i = 0; i < e.size(); i++) chk({nm, "_tag"}, DW'(deliv[i]), DW'(e[i]));
  endtask

  initial begin
    int          eg [$];
    logic [15:0] ed [$];
    cyc = 0;
    req_valid = '0;
    req_data = '0;
    wr = 1'b1;
    do_reset();

    // Single burst on port 0.
    pq[0].push_back(mk(8'h00, 8'h01, 8'h10));
    pq[0].push_back(mk(8'h00, 8'h02, DONE));
    run();
    eg = '{0}; chk_glog("t1", eg);
    ed = '{16'h0001, 16'h0002}; chk_deliv("t1", ed);
    chk("t1_gap", DW'(deliv_cyc[1] - deliv_cyc[0]), DW'(1));
    chk("t1_busy_end", DW'(busy), DW'(0));
`ifdef WRDM_ARB_STATS_EN
    chk("t1_cnt0", DW'(burst_cnt[31:0]), DW'(1));
`endif

    // Ports 0 and 2 together.
    do_reset();
    pq[0].push_back(mk(8'h00, 8'h01, 8'h10));
    pq[0].push_back(mk(8'h00, 8'h02, DONE));
    pq[2].push_back(mk(8'h02, 8'h01, 8'h10));
    pq[2].push_back(mk(8'h02, 8'h02, DONE));
    run();
    eg = '{0, 2}; chk_glog("t2", eg);
    ed = '{16'h0001, 16'h0002, 16'h0201, 16'h0202}; chk_deliv("t2", ed);

    // Port 1 burst with a three-cycle output stall.
    do_reset();
    pq[1].push_back(mk(8'h01, 8'h01, 8'h10));
    pq[1].push_back(mk(8'h01, 8'h02, 8'h11));
    pq[1].push_back(mk(8'h01, 8'h03, DONE));
    rp = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    run();
    eg = '{1}; chk_glog("t3", eg);
    ed = '{16'h0101, 16'h0102, 16'h0103}; chk_deliv("t3", ed);

    // All four ports, two bursts each.
    do_reset();
    for (int b = 0; b < 2; b++)
      for (int p = 0; p < N; p++) begin
        pq[p].push_back(mk(8'(p), 8'(2*b + 1), 8'h10));
        pq[p].push_back(mk(8'(p), 8'(2*b + 2), DONE));
      end
    run();
    eg = '{0, 1, 2, 3, 0, 1, 2, 3}; chk_glog("t4", eg);
`ifdef WRDM_ARB_STATS_EN
    for (int p = 0; p < N; p++) chk("t4_cnt", DW'(burst_cnt[p*32 +: 32]), DW'(2));
`endif

    // Reset while port 3 is locked with a pending output.
    do_reset();
    pq[3].push_back(mk(8'h03, 8'h01, 8'h10));
    pq[3].push_back(mk(8'h03, 8'h02, 8'h11));
    pq[3].push_back(mk(8'h03, 8'h03, DONE));
    rp = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    drive();
    step(); step(); step();
    chk("t5_pre_busy", DW'(busy), DW'(1));
    chk("t5_pre_grant", DW'(grant_id), DW'(3));
    chk("t5_pre_valid", DW'(wv), DW'(1));
    do_reset();
    pq[3].push_back(mk(8'h03, 8'h04, DONE));
    pq[0].push_back(mk(8'h00, 8'h01, DONE));
    run();
    eg = '{0, 3}; chk_glog("t5", eg);
    ed = '{16'h0001, 16'h0304}; chk_deliv("t5", ed);

    // Non-done ID FD keeps the lock.
    do_reset();
    pq[1].push_back(mk(8'h01, 8'h01, 8'h10));
    pq[1].push_back(mk(8'h01, 8'h02, 8'hFD));
    pq[1].push_back(mk(8'h01, 8'h03, 8'h10));
    pq[1].push_back(mk(8'h01, 8'h04, DONE));
    pq[2].push_back(mk(8'h02, 8'h01, DONE));
    run();
    eg = '{1, 2}; chk_glog("t6", eg);
    ed = '{16'h0101, 16'h0102, 16'h0103, 16'h0104, 16'h0201}; chk_deliv("t6", ed);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wrdm_desc_arb.md
# wrdm_desc_arb

Round-robin arbiter sharing the single write-data-mover descriptor port among several FPGA-to-CPU ring-buffer DMA engines, one per CPU ring. Each engine issues a burst of 174-bit descriptors: one or two data descriptors, then one done descriptor. The arbiter locks the grant for a whole burst, so descriptors from different rings never interleave and a done (tail-update) descriptor always directly follows its own data. It sits between the per-ring DMA engines and the PCIe write data mover's descriptor input.

## Interface
- NUM_PORTS, 4: number of requesting DMA engines (2..8).
- DESC_W, 174: descriptor width.
- DONE_ID, 8'hFE: descriptor ID that marks the end of a burst; the ID field is bits [159:152].
- clk  in  1  sole clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- req_valid  in  NUM_PORTS  per-port descriptor valid.
- req_data  in  NUM_PORTS*DESC_W  per-port descriptor; port i occupies [i*DESC_W +: DESC_W].
- req_ready  out  NUM_PORTS  per-port descriptor accepted.
- wrdm_desc_valid  out  1  descriptor valid to the write data mover.
- wrdm_desc_data  out  DESC_W  descriptor to the write data mover.
- wrdm_desc_ready  in  1  the write data mover accepts a descriptor.
- grant_id  out  $clog2(NUM_PORTS)  currently or last granted port.
- busy  out  1  a burst is locked.
- burst_cnt  out  NUM_PORTS*32  completed bursts per port (only with WRDM_ARB_STATS_EN).

## Operation
- All handshakes are valid/ready: a transfer occurs on a rising clk edge with valid & ready both high. Once valid is raised, a requester holds valid and data stable until the transfer.
- State machine has two states, IDLE and LOCKED.
- IDLE:
  - All req_ready are 0.
  - If any req_valid is set, pick the first set bit searching upward (with wrap) from last_grant+1.
  - Register the winner into grant_id and go to LOCKED.
  - With no requests, remain in IDLE.
- LOCKED:
  - req_ready[grant_id] = ~wrdm_desc_valid | wrdm_desc_ready. All other req_ready are 0.
  - Each accepted descriptor is copied unmodified into the output register and wrdm_desc_valid is set.
  - When the output is consumed and no new descriptor is accepted, wrdm_desc_valid is cleared.
  - When an accepted descriptor has data[159:152] == DONE_ID: set last_grant = grant_id, go to IDLE.
  - The output register may still hold that done descriptor on entry to IDLE; it drains normally.
- busy = (state == LOCKED).
- Any number of data descriptors per burst is allowed. A requester that never sends DONE_ID holds the lock indefinitely; this is by design.
- A port deasserting req_valid mid-burst keeps the lock.
- A request arriving for a non-granted port waits; there is no preemption.
- last_grant resets to NUM_PORTS-1, so port 0 wins first.

## Timing
- Reset values: state=IDLE, wrdm_desc_valid=0, wrdm_desc_data=0, req_ready=0, grant_id=0, last_grant=NUM_PORTS-1, busy=0, burst_cnt=0.
- Arbitration: request seen in IDLE at cycle t gives busy=1 and the granted port's req_ready=1 at t+1.
- Latency: a descriptor accepted at edge t appears on wrdm_desc_valid/data after edge t (one register stage).
- Throughput:
  - One descriptor per cycle while wrdm_desc_ready stays high.
  - One mandatory IDLE cycle between bursts.
- Simultaneous events: a new accept and an output consume on the same edge replace the output register, and valid stays 1.
- Reset mid-burst: all state clears immediately, including any in-flight output descriptor. Upstream engines must also be reset.

## Configuration
- WRDM_ARB_STATS_EN defined:
  - burst_cnt[i] increments by 1 on each accepted DONE_ID descriptor from port i.
  - The count wraps at 2^32 and is cleared only by reset.
- Not defined: the burst_cnt port and its counters are absent.

## Test plan
- Single burst on port 0: data descriptor, then a done descriptor (ID FE), wrdm_desc_ready=1 throughout -> both descriptors appear on consecutive cycles, each 1 cycle after acceptance; busy returns to 0; burst_cnt[0]=1.
- Ports 0 and 2 raise valid in the same cycle -> port 0's full burst first, one IDLE cycle, then port 2's burst; no interleaving; grant_id sequence 0 then 2.
- Wrap burst on port 1 (two data descriptors plus done), wrdm_desc_ready low for 3 cycles after the first descriptor -> req_ready[1]=0 during the stall; descriptors delivered unmodified and in order.
- All 4 ports continuously requesting for 8 bursts -> grant order 0,1,2,3,0,1,2,3; each burst_cnt=2.
- rst_n asserted while port 3 is locked and wrdm_desc_valid=1 -> all outputs go to reset values without waiting for clk; after release, port 0 (last_grant=3) wins first.
- A descriptor with ID FD (not DONE_ID) -> the lock is held, with no other port granted, until an FE descriptor is accepted.
